// File: rtl/lsu_wb_master.sv
// Load/store unit front end: turns one CPU access into a single pipelined
// Wishbone cycle, lane-aligns store data, and extends load data.
// Misaligned requests and silent slaves complete with an error so the core never hangs.
module lsu_wb_master #(
    parameter int ADDR_WIDTH = 10,
    parameter int TIMEOUT    = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req,
    input  logic                  i_we,
    input  logic [31:0]           i_addr,
    input  logic [31:0]           i_wdata,
    input  logic [1:0]            i_size,
    input  logic                  i_unsigned,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic [31:0]           o_rdata,
    output logic                  o_wb_cyc,
    output logic                  o_wb_stb,
    output logic                  o_wb_we,
    output logic [ADDR_WIDTH-1:0] o_wb_addr,
    output logic [31:0]           o_wb_data,
    output logic [3:0]            o_wb_sel,
    input  logic                  i_wb_ack,
    input  logic                  i_wb_stall,
    input  logic [31:0]           i_wb_data
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STROBE,
        S_WAIT_ACK,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic                  pend_q, pend_d;
    logic                  we_q, we_d;
    logic                  uns_q, uns_d;
    logic [1:0]            size_q, size_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [31:0]           rdata_q, rdata_d;

    logic [1:0]            off;
    logic                  misaligned;
    logic [3:0]            lane_sel;
    logic [31:0]           lane_data;
    logic [31:0]           shifted;
    logic [31:0]           load_val;
    logic                  in_cycle;

    assign off = addr_q[1:0];

    // Byte-lane select, replicated store data and alignment check for the latched request
    always_comb begin
        lane_sel   = 4'b1111;
        lane_data  = wdata_q;
        misaligned = 1'b0;
        case (size_q)
            2'b00: begin
                lane_sel  = 4'b0001 << off;
                lane_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                lane_sel   = addr_q[1] ? 4'b1100 : 4'b0011;
                lane_data  = {2{wdata_q[15:0]}};
                misaligned = addr_q[0];
            end
            default: begin
                lane_sel   = 4'b1111;
                lane_data  = wdata_q;
                misaligned = (off != 2'b00);
            end
        endcase
    end

    // Right-justify the addressed lanes of the returned word and sign/zero extend
    always_comb begin
        shifted  = i_wb_data >> {off, 3'b000};
        load_val = shifted;
        case (size_q)
            2'b00:   load_val = uns_q ? {24'h000000, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = uns_q ? {16'h0000, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    // Next-state logic: request capture, bus handshake, timeout and completion.
    // A request is latched in IDLE and decoded one cycle later (pend_q), which
    // is what gives the one-cycle gap before cyc rises or an error completes.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        we_d    = we_q;
        uns_d   = uns_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (pend_q) begin
                    pend_d = 1'b0;
                    if (misaligned) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = S_STROBE;
                    end
                end else if (i_req) begin
                    pend_d  = 1'b1;
                    we_d    = i_we;
                    uns_d   = i_unsigned;
                    size_d  = i_size;
                    addr_d  = i_addr[ADDR_WIDTH-1:0];
                    wdata_d = i_wdata;
                end
            end
            S_STROBE: begin
                if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (!i_wb_stall) begin
                        state_d = S_WAIT_ACK;
                    end
                end
            end
            S_WAIT_ACK: begin
                if (i_wb_ack) begin
                    if (!we_q) begin
                        rdata_d = load_val;
                    end
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset is asynchronous so the bus drops at once
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            pend_q  <= 1'b0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Bus and CPU outputs decoded from registered state; bus fields are zero outside a cycle
    always_comb begin
        in_cycle  = (state_q == S_STROBE) || (state_q == S_WAIT_ACK);
        o_wb_cyc  = in_cycle;
        o_wb_stb  = (state_q == S_STROBE);
        o_wb_we   = in_cycle & we_q;
        o_wb_addr = in_cycle ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
        o_wb_data = in_cycle ? lane_data : '0;
        o_wb_sel  = in_cycle ? lane_sel : 4'b0000;
        o_busy    = pend_q | in_cycle;
        o_done    = (state_q == S_DONE);
        o_err     = (state_q == S_DONE) & err_q;
        o_rdata   = rdata_q;
    end

endmodule

// File: doc/lsu_wb_master.md
# lsu_wb_master

Load/store bus master sitting directly upstream of the combined instruction/data memory slave. It takes one CPU access request at a time, with byte, half-word or word size, and issues a single pipelined Wishbone cycle. The master generates `o_wb_sel` and the byte-lane-aligned write data. On reads it returns the sign- or zero-extended result to the CPU, with a done/error pulse. Misaligned accesses and unresponsive slaves (timeout) complete with an error instead of hanging the core.

## Interface
- `ADDR_WIDTH`, default 10: width of `o_wb_addr`, matching the memory slave's address width.
- `TIMEOUT`, default 16: number of cycles with `o_wb_cyc` high, without ack, before the access is aborted. Must be ≥2.

Ports:
- `i_clk`, in, 1: the single clock; all logic is on the rising edge.
- `i_rst`, in, 1: asynchronous, active-high reset.
- `i_req`, in, 1: access request, sampled only when `o_busy`=0.
- `i_we`, in, 1: 1 = store, 0 = load.
- `i_addr`, in, 32: byte address.
- `i_wdata`, in, 32: store data, right-justified.
- `i_size`, in, 2: 00 = byte, 01 = half, 10 = word; 11 is treated as word.
- `i_unsigned`, in, 1: load zero-extends when set, sign-extends otherwise.
- `o_busy`, out, 1: high from the cycle after acceptance until `o_done`.
- `o_done`, out, 1: one-cycle completion pulse.
- `o_err`, out, 1: qualifies `o_done`; high for misalignment or timeout.
- `o_rdata`, out, 32: extended load result, valid with `o_done`.
- `o_wb_cyc`, `o_wb_stb`, `o_wb_we`, out, 1 each: Wishbone cycle, strobe and write-enable.
- `o_wb_addr`, out, `ADDR_WIDTH`: `{i_addr[ADDR_WIDTH-1:2], 2'b00}`.
- `o_wb_data`, out, 32: lane-aligned write data.
- `o_wb_sel`, out, 4: byte-lane select.
- `i_wb_ack`, `i_wb_stall`, in, 1 each: slave acknowledge and stall.
- `i_wb_data`, in, 32: slave read data.

## Operation
- **FSM states:** IDLE, STROBE, WAIT_ACK, DONE.
- **IDLE:**
  - Samples `i_req`. On `i_req`=1, latches the address, size, store/load, unsigned flag and store data.
  - Misaligned request (half with addr[0]=1, or word with addr[1:0]≠0): goes to DONE with the error flag set and starts no bus cycle.
  - Aligned request: goes to STROBE.
- **Lane mapping** (off = addr[1:0]):
  - Byte: sel = 4'b0001<<off; data = {4{wdata[7:0]}}.
  - Half: sel = addr[1] ? 4'b1100 : 4'b0011; data = {2{wdata[15:0]}}.
  - Word: sel = 4'b1111; data = wdata.
- **STROBE:** `o_wb_cyc`=`o_wb_stb`=1. If `i_wb_stall`=0, goes to WAIT_ACK next edge with stb dropped; otherwise stays.
- **WAIT_ACK:** `o_wb_cyc`=1, `o_wb_stb`=0. On `i_wb_ack`=1:
  - Load: captures `i_wb_data` >> (8·off), then extends from bit 7 (byte) or bit 15 (half); word is unchanged.
  - Goes to DONE.
- **Ack rule:** ack is sampled only in WAIT_ACK; ack seen during STROBE is ignored. At most one transaction is outstanding.
- **Timeout:** a counter is cleared on entering STROBE and increments each cycle in STROBE/WAIT_ACK. When it reaches `TIMEOUT`-1 without ack, the FSM goes to DONE with error, drops cyc, and leaves `o_rdata` unchanged.
- **DONE:** drives the `o_done`=1 pulse (with `o_err` set per the error flag) and `o_busy`=0, then returns to IDLE. A new `i_req` is accepted in the cycle after DONE, not during DONE.
- **Other rules:**
  - Stores and error completions never modify `o_rdata`.
  - `i_req` while `o_busy`=1 is ignored; it is not queued.

## Timing
- **Reset:** all outputs are 0, state is IDLE, the counter is 0. Reset during STROBE/WAIT_ACK drops `o_wb_cyc`/`o_wb_stb` immediately (asynchronously) and never pulses `o_done`.
- **Latency with a zero-stall slave that acks one cycle after stb:**
  - Request sampled at edge E.
  - cyc/stb high after E+1.
  - ack sampled at E+3.
  - `o_done` high for the cycle after E+3, so the request-to-done latency is 4 edges.
- **Stall:** each stall cycle adds 1 cycle.
- **Misaligned access:** `o_done`/`o_err` is high for the cycle after E+1, and `o_wb_cyc` never rises.
- **Bus signal stability:** `o_wb_addr`, `o_wb_sel`, `o_wb_we` and `o_wb_data` are stable while `o_wb_cyc`=1.
- **Back-to-back throughput:** one access per 5 cycles.

## Test plan
- **Word store then load:**
  - Store 32'hDEADBEEF to addr 0x40.
  - Expect sel=4'b1111 and `o_wb_addr`=0x40.
  - Load 0x40: `o_rdata`=32'hDEADBEEF, `o_done` 4 edges after request, `o_err`=0.
- **Byte lanes:**
  - Store byte 0x80 to 0x43: sel=4'b1000, data=32'h80808080.
  - Signed byte load of 0x43 → 32'hFFFFFF80; unsigned load → 32'h00000080.
- **Half-word:**
  - Store 16'h8001 to 0x22: sel=4'b1100.
  - Signed load → 32'hFFFF8001; unsigned load → 32'h00008001.
- **Misalignment:**
  - Word access at 0x41 and half access at 0x23: `o_done`=`o_err`=1 one cycle after acceptance.
  - No cyc pulse; `o_rdata` unchanged.
- **Stall and timeout:**
  - Hold `i_wb_stall`=1 for 3 cycles: `o_done` 3 cycles later than nominal, with bus signals stable throughout.
  - Hold ack at 0: cyc drops and `o_done`+`o_err` pulse after `TIMEOUT` cycles of cyc.
- **Reset and ignored requests:**
  - Assert `i_rst` during WAIT_ACK: cyc and stb go to 0 immediately, no `o_done`.
  - After release, a fresh load completes normally.
  - `i_req` pulsed while busy is ignored.
